// File: rtl/mem_pkg.sv
// Shared definitions for the load/store controller: state encoding, access
// sizes and the fixed accept-to-response latencies of each request kind.
package mem_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t ACC0 = 3'd1;
    localparam state_t ACC1 = 3'd2;
    localparam state_t FIN  = 3'd3;
    localparam state_t RESP = 3'd4;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_HALF = 1'b1;

    // Cycles from the accept edge to the resp_valid cycle.
    localparam int LAT_ST_BYTE = 2;
    localparam int LAT_ST_HALF = 3;
    localparam int LAT_LD_BYTE = 3;
    localparam int LAT_LD_HALF = 4;
    localparam int LAT_ERR     = 1;

endpackage

// File: rtl/mem_ctrl.sv
// Byte/half-word load/store controller in front of a byte-wide synchronous RAM
// with one-cycle read latency. Half-words are little-endian, two byte accesses.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    // Request: transfer on a rising edge where req_valid && req_ready; fields
    // are sampled only then. Response: resp_valid is a one-cycle pulse and is
    // never back-pressured.
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic               req_size,
    input  logic [AW-1:0]      req_addr,
    input  logic [2*WIDTH-1:0] req_wdata,
    output logic               resp_valid,
    output logic [2*WIDTH-1:0] resp_rdata,
    output logic               resp_err,
    output logic               mem_we,
    output logic               mem_re,
    output logic [AW-1:0]      mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic [2:0]         fsm_state
);

    state_t               state;
    state_t               state_nx;
    logic                 lat_we;
    logic                 lat_size;
    logic [AW-1:0]        lat_addr;
    logic [2*WIDTH-1:0]   lat_wdata;
    logic [2*WIDTH-1:0]   rdata;
    logic                 err;
    logic                 half_at_end;
    logic                 in_acc;

    // A half-word at the last address would need addr+1 to wrap; reject it.
    assign half_at_end = (req_size == SIZE_HALF) && (req_addr == AW'(DEPTH - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_valid) state_nx = half_at_end ? RESP : ACC0;
            ACC0: begin
                if (lat_size == SIZE_HALF) state_nx = ACC1;
                else if (lat_we)           state_nx = RESP;
                else                       state_nx = FIN;
            end
            ACC1:    state_nx = lat_we ? RESP : FIN;
            FIN:     state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_size  <= SIZE_BYTE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_size  <= req_size;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        rdata     <= '0;
                        err       <= half_at_end;
                    end
                end
                // RAM data from the ACC0 read is on mem_rdata during ACC1.
                ACC1: if (!lat_we) rdata[WIDTH-1:0] <= mem_rdata;
                FIN: begin
                    if (lat_size == SIZE_HALF) rdata[2*WIDTH-1:WIDTH] <= mem_rdata;
                    else                       rdata[WIDTH-1:0]       <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign in_acc = (state == ACC0) || (state == ACC1);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ACC0) begin
            mem_addr = lat_addr;
            if (lat_we) mem_wdata = lat_wdata[WIDTH-1:0];
        end else if (state == ACC1) begin
            mem_addr = lat_addr + AW'(1);
            if (lat_we) mem_wdata = lat_wdata[2*WIDTH-1:WIDTH];
        end
    end

    assign mem_we     = in_acc && lat_we;
    assign mem_re     = in_acc && !lat_we;
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata;
    assign resp_err   = err;
    assign fsm_state  = state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural byte RAM, directed scenarios,
// then randomized requests scored against an array-based memory model.
module tb_mem_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_size = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [15:0] req_wdata = 16'h0000;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  wire  [7:0]  mem_rdata;
  logic [2:0]  fsm_state;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  ref_mem [256];

  int we_total = 0;
  int re_total = 0;
  int resp_total = 0;
  int overlap_cnt = 0;
  int xz_cnt = 0;

  mem_ctrl #(.WIDTH(8), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    if (i == 'h40) return 8'h7E;
    return 8'(i * 29 + 3);
  endfunction

  // Behavioural synchronous RAM: data valid the cycle after re, Z otherwise.
  logic [7:0] ram_mem [256];
  logic [7:0] ram_q = 8'h00;
  logic       ram_oe = 1'b0;
  logic       ram_init_done = 1'b0;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_byte(i);
      ram_init_done <= 1'b1;
    end else if (mem_we) begin
      ram_mem[mem_addr] <= mem_wdata;
    end
    if (mem_re) ram_q <= ram_mem[mem_addr];
    ram_oe <= mem_re;
  end

  assign mem_rdata = ram_oe ? ram_q : 8'bz;

  always @(negedge clk) begin
    if (mem_we) we_total++;
    if (mem_re) re_total++;
    if (mem_we && mem_re) overlap_cnt++;
    if (resp_valid) begin
      resp_total++;
      if ($isunknown(resp_rdata) || $isunknown(resp_err)) xz_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full request: model update, drive, wait for response, score.
  task automatic do_txn(input logic we, input logic size, input logic [7:0] addr,
                        input logic [15:0] wdata);
    logic [7:0]  a1;
    logic [15:0] exp_rd;
    logic [15:0] got_rd;
    logic        exp_err;
    logic        got_err;
    logic        got;
    int exp_lat, lat, exp_we, exp_re, we0, re0, rbad, wait_cyc;
    a1 = addr + 8'd1;
    exp_err = size && (addr == 8'hFF);
    exp_rd = 16'h0000;
    exp_we = 0;
    exp_re = 0;
    if (exp_err) begin
      exp_lat = LAT_ERR;
    end else if (we) begin
      ref_mem[addr] = wdata[7:0];
      exp_we = 1;
      if (size) begin
        ref_mem[a1] = wdata[15:8];
        exp_we = 2;
      end
      exp_lat = size ? LAT_ST_HALF : LAT_ST_BYTE;
    end else begin
      exp_rd = size ? {ref_mem[a1], ref_mem[addr]} : {8'h00, ref_mem[addr]};
      exp_re = size ? 2 : 1;
      exp_lat = size ? LAT_LD_HALF : LAT_LD_BYTE;
    end
    exp_q.push_back(exp_rd);

    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_addr = addr;
    req_wdata = wdata;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_eq("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    we0 = we_total;
    re0 = re_total;
    lat = 0;
    got = 1'b0;
    rbad = 0;
    got_rd = 16'h0000;
    got_err = 1'b0;
    while (!got && lat < 16) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (req_ready) rbad++;
      if (resp_valid) begin
        got = 1'b1;
        got_rd = resp_rdata;
        got_err = resp_err;
      end
    end
    check_eq("resp_seen", 32'(got), 32'd1);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("resp_rdata", 32'(got_rd), 32'(exp_q.pop_front()));
    check_eq("resp_err", 32'(got_err), 32'(exp_err));
    check_eq("ready_low_busy", 32'(rbad), 32'd0);
    check_eq("we_pulses", 32'(we_total - we0), 32'(exp_we));
    check_eq("re_pulses", 32'(re_total - re0), 32'(exp_re));
    @(negedge clk);
    check_eq("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int n, m, r0, diff;
    logic [7:0] ra;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_outs_a", {28'd0, resp_valid, resp_err, mem_we, mem_re}, 32'd0);
    check_eq("rst_outs_b", {mem_addr, mem_wdata, resp_rdata}, 32'd0);
    check_eq("rst_state", 32'(fsm_state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);

    // Byte store then byte load
    do_txn(1'b1, SIZE_BYTE, 8'h10, 16'h00A5);
    check_eq("ram_10", 32'(ram_mem[8'h10]), 32'h0A5);
    do_txn(1'b0, SIZE_BYTE, 8'h10, 16'h0000);

    // Half store then half load, little-endian
    do_txn(1'b1, SIZE_HALF, 8'h20, 16'hBEEF);
    check_eq("ram_20", 32'(ram_mem[8'h20]), 32'h0EF);
    check_eq("ram_21", 32'(ram_mem[8'h21]), 32'h0BE);
    do_txn(1'b0, SIZE_HALF, 8'h20, 16'h0000);

    // Half access at the last address is an error without RAM traffic
    do_txn(1'b0, SIZE_HALF, 8'hFF, 16'h0000);
    do_txn(1'b1, SIZE_HALF, 8'hFF, 16'h5A5A);
    do_txn(1'b0, SIZE_BYTE, 8'hFF, 16'h0000);

    // Back-to-back with req_valid held high
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = SIZE_BYTE;
    req_addr = 8'h01;
    req_wdata = 16'h0011;
    ref_mem[8'h01] = 8'h11;
    ref_mem[8'h02] = 8'h22;
    @(posedge clk);
    @(negedge clk);
    req_addr = 8'h02;
    req_wdata = 16'h0022;
    n = 1;
    while (!resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("b2b_first_lat", 32'(n), 32'(LAT_ST_BYTE));
    check_eq("b2b_ready_in_resp", 32'(req_ready), 32'd0);
    m = 0;
    do begin
      @(negedge clk);
      m++;
      if (m == 1) check_eq("b2b_ready_idle", 32'(req_ready), 32'd1);
    end while (!resp_valid && m < 10);
    req_valid = 1'b0;
    check_eq("b2b_gap", 32'(m), 32'(1 + LAT_ST_BYTE));
    repeat (2) @(negedge clk);
    check_eq("b2b_ram_01", 32'(ram_mem[8'h01]), 32'h11);
    check_eq("b2b_ram_02", 32'(ram_mem[8'h02]), 32'h22);

    // Reset during ACC0 of a half store
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = SIZE_HALF;
    req_addr = 8'h30;
    req_wdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort_in_acc0_we", 32'(mem_we), 32'd1);
    r0 = resp_total;
    rst_n = 1'b0;
    #1;
    check_eq("abort_outs_a", {28'd0, resp_valid, resp_err, mem_we, mem_re}, 32'd0);
    check_eq("abort_outs_b", {mem_addr, mem_wdata, resp_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check_eq("abort_no_resp", 32'(resp_total - r0), 32'd0);
    check_eq("abort_ram_30", 32'(ram_mem[8'h30]), 32'(ref_mem[8'h30]));
    check_eq("abort_ram_31", 32'(ram_mem[8'h31]), 32'(ref_mem[8'h31]));

    // Load of an initialised location right after a store
    do_txn(1'b1, SIZE_BYTE, 8'h50, 16'h0033);
    do_txn(1'b0, SIZE_BYTE, 8'h40, 16'h0000);

    // Randomized requests
    for (int k = 0; k < 60; k++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, 16'($urandom));
    end

    repeat (2) @(negedge clk);
    diff = 0;
    for (int i = 0; i < 256; i++) if (ram_mem[i] !== ref_mem[i]) diff++;
    check_eq("ram_image", 32'(diff), 32'd0);
    check_eq("we_re_exclusive", 32'(overlap_cnt), 32'd0);
    check_eq("resp_no_xz", 32'(xz_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Load/store controller between CPU core datapath and the byte-wide synchronous RAM (1-cycle read latency; RAM output is high-Z when not read-enabled).
- Accepts one request at a time from the core via a valid/ready handshake.
- Supports byte and little-endian 16-bit half-word access; a half-word is split into two sequential byte accesses.
- Drives the RAM's we/re/addr/data_in and returns read data with a single-cycle response pulse.

Parameters:
- WIDTH, 8, RAM word width in bits.
- DEPTH, 256, RAM words.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents request.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_size  in  1  0=byte, 1=half-word.
- req_addr  in  AW  byte address.
- req_wdata  in  2*WIDTH  store data; byte uses [WIDTH-1:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  2*WIDTH  load data, zero-extended for byte loads; 0 for stores.
- resp_err  out  1  qualified by resp_valid; half-word at addr DEPTH-1.
- mem_we  out  1  to RAM we.
- mem_re  out  1  to RAM re.
- mem_addr  out  AW  to RAM addr.
- mem_wdata  out  WIDTH  to RAM data_in.
- mem_rdata  in  WIDTH  from RAM data_out (valid the cycle after mem_re=1; Z otherwise).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1 once released; resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0. Reset mid-operation aborts immediately: no further RAM strobes, no response.
- Accept on clk edge with req_valid&&req_ready; latch we/size/addr/wdata. req_ready=0 in every state except IDLE.
- States: IDLE, ACC0, ACC1, FIN, RESP.
- IDLE -> ACC0 on accept; -> RESP directly (resp_err=1, no RAM access) if size=1 and addr=DEPTH-1.
- ACC0: mem_addr=addr; store: mem_we=1, mem_wdata=wdata[7:0]; load: mem_re=1. Next: ACC1 if half; else FIN if load; else RESP.
- ACC1: mem_addr=addr+1; store: mem_we=1, mem_wdata=wdata[15:8]; load: mem_re=1 and capture mem_rdata into rdata[7:0]. Next: FIN if load, else RESP.
- FIN (loads only): mem_re=0, mem_we=0; capture mem_rdata into rdata[7:0] (byte) or rdata[15:8] (half). Next: RESP.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err stable; -> IDLE. No back-pressure on response.
- mem_we/mem_re are never both 1. Both are 0 in IDLE, FIN and RESP.
- Latency (accept edge to resp_valid cycle): byte store 2, half store 3, byte load 3, half load 4, error 1.
- mem_rdata is sampled only in the cycle after mem_re=1; resp_rdata must never carry X/Z.
- addr+1 is computed in AW bits. Wrap is impossible because the DEPTH-1 case is rejected as an error.
- resp_rdata is cleared to 0 at accept, so stale data never leaks into a later response.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE, ACC0, ACC1, FIN, RESP),
  - SIZE_BYTE=1'b0 and SIZE_HALF=1'b1,
  - latency constants for the bench.
- No sub-module: a single FSM plus datapath registers.
- The testbench pairs this block with the existing ram instance (WIDTH=8, DEPTH=256).

Test Plan:
- Byte store addr 0x10 data 0xA5, then byte load 0x10 -> one mem_we pulse at 0x10 with 0xA5; load returns resp_rdata=0x00A5, resp_err=0, 3 cycles after accept.
- Half store addr 0x20 data 0xBEEF, then half load 0x20 -> RAM[0x20]=0xEF, RAM[0x21]=0xBE; load returns 0xBEEF at 4-cycle latency; req_ready low throughout.
- Half load addr 0xFF -> resp_valid 1 cycle after accept with resp_err=1, resp_rdata=0; mem_re/mem_we never asserted.
- req_valid held high for back-to-back requests (byte store 0x01=0x11, byte store 0x02=0x22) -> second accepted only in the IDLE cycle after the first RESP; both locations written correctly.
- rst_n pulled low during ACC0 of a half store to 0x30 data 0x1234 -> outputs go to reset values immediately; RAM[0x31] unchanged; req_ready=1 after release; no resp_valid.
- Byte load of an unwritten-but-initialised location 0x40=0x7E immediately after a store completes -> resp_rdata=0x007E, no X/Z bits at any resp_valid.
